// File: rtl/dmem_write_buffer_if.sv
// dmem_write_buffer_if
//   Bundles the controller-side command signals and the memory-side write/read
//   port of the posted-write buffer.
//   slave  : the write buffer itself (takes CPU commands and memory ready,
//            drives stall, memory request/address/data and empty status)
//   master : the surrounding controller/memory model
// Signals
//   Cpu_Address[31:0]     byte address (only [31:2] used)
//   Cpu_WriteData[31:0]   lane-aligned store data
//   Cpu_WriteEnable[3:0]  per-byte store enables, 0 = no store
//   Cpu_ReadEnable        load request
//   Drain                 barrier: empty the buffer before proceeding
//   Stall                 controller must hold its current command
//   Mem_Address[29:0]     word address to memory
//   Mem_WriteData[31:0]   head-entry data
//   Mem_WriteEnable[3:0]  head-entry byte enables
//   Mem_WriteReq          head-entry write valid
//   Mem_WriteReady        memory accepts the write this cycle
//   Mem_ReadEnable        load forwarded to memory
//   Empty                 no entries queued
interface dmem_write_buffer_if;
   logic [31:0] Cpu_Address;
   logic [31:0] Cpu_WriteData;
   logic [3:0]  Cpu_WriteEnable;
   logic        Cpu_ReadEnable;
   logic        Drain;
   logic        Stall;
   logic [29:0] Mem_Address;
   logic [31:0] Mem_WriteData;
   logic [3:0]  Mem_WriteEnable;
   logic        Mem_WriteReq;
   logic        Mem_WriteReady;
   logic        Mem_ReadEnable;
   logic        Empty;

   modport slave (
      input  Cpu_Address, Cpu_WriteData, Cpu_WriteEnable, Cpu_ReadEnable,
             Drain, Mem_WriteReady,
      output Stall, Mem_Address, Mem_WriteData, Mem_WriteEnable,
             Mem_WriteReq, Mem_ReadEnable, Empty
   );

   modport master (
      output Cpu_Address, Cpu_WriteData, Cpu_WriteEnable, Cpu_ReadEnable,
             Drain, Mem_WriteReady,
      input  Stall, Mem_Address, Mem_WriteData, Mem_WriteEnable,
             Mem_WriteReq, Mem_ReadEnable, Empty
   );
endinterface

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
//   Posted-write buffer between the data memory controller and the memory port.
//   Byte-enabled stores are queued so the pipeline does not wait for write
//   acceptance; a store to the newest queued word merges into it; entries
//   drain in FIFO order; loads bypass the queue and have bus priority.
//   Stall is raised on a load hitting a queued word, on a store that finds the
//   buffer full with no merge possible, and on Drain while entries remain.
// Ports
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, discards all queued stores
//   bus   : dmem_write_buffer_if.slave (CPU command side and memory side)
// Parameters
//   DEPTH : number of entries (power of two, >= 2)
//   PTR_W : log2(DEPTH)
module dmem_write_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   dmem_write_buffer_if.slave   bus
);

   logic [29:0]    r_addr  [DEPTH];
   logic [31:0]    r_data  [DEPTH];
   logic [3:0]     r_be    [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;

   logic [29:0]      w_cpu_word;
   logic [PTR_W-1:0] w_tail_m1;
   logic             w_empty;
   logic             w_full;
   logic             w_store;
   logic             w_conflict;
   logic             w_addr_hits_tail;
   logic             w_full_stall;
   logic             w_stall;
   logic             w_read;
   logic             w_write_req;
   logic             w_pop;
   logic             w_merge;
   logic             w_push;
   logic [1:0]       w_unused_addr_lsb;

   assign w_cpu_word        = bus.Cpu_Address[31:2];
   assign w_unused_addr_lsb = bus.Cpu_Address[1:0];
   assign w_tail_m1         = r_tail - PTR_W'(1);
   assign w_empty           = (r_count == '0);
   assign w_full            = (r_count == (PTR_W+1)'(DEPTH));
   assign w_store           = |bus.Cpu_WriteEnable;

   always_comb begin
      w_conflict = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (r_addr[i] == w_cpu_word)) begin
            w_conflict = 1'b1;
         end
      end
      w_conflict = w_conflict & bus.Cpu_ReadEnable;
   end

   // Address match against the newest entry, evaluated without the pop term so
   // the full-stall path does not loop through the memory handshake. At full
   // the count==1 pop exclusion can never apply since DEPTH >= 2.
   assign w_addr_hits_tail = !w_empty && (r_addr[w_tail_m1] == w_cpu_word);
   assign w_full_stall     = w_store && w_full && !w_addr_hits_tail;

   assign w_stall     = w_conflict || w_full_stall || (bus.Drain && !w_empty);
   assign w_read      = bus.Cpu_ReadEnable && !w_stall;
   assign w_write_req = !w_empty && !w_read;
   assign w_pop       = w_write_req && bus.Mem_WriteReady;

   // A sole entry leaving this cycle cannot absorb a merge; push a new one.
   assign w_merge = w_store && !w_stall && w_addr_hits_tail &&
                    !((r_count == (PTR_W+1)'(1)) && w_pop);
   assign w_push  = w_store && !w_stall && !w_merge;

   assign bus.Stall           = w_stall;
   assign bus.Mem_ReadEnable  = w_read;
   assign bus.Mem_WriteReq    = w_write_req;
   assign bus.Mem_Address     = w_read ? w_cpu_word : r_addr[r_head];
   assign bus.Mem_WriteData   = r_data[r_head];
   assign bus.Mem_WriteEnable = r_be[r_head];
   assign bus.Empty           = w_empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
            r_be[i]   <= '0;
         end
      end else begin
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PTR_W'(1);
         end
         // Push and pop never target the same slot: equal pointers imply
         // empty (no pop) or full (no push).
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_addr[r_tail]  <= w_cpu_word;
            r_data[r_tail]  <= bus.Cpu_WriteData;
            r_be[r_tail]    <= bus.Cpu_WriteEnable;
            r_tail          <= r_tail + PTR_W'(1);
         end
         if (w_merge) begin
            for (int unsigned b = 0; b < 4; b++) begin
               if (bus.Cpu_WriteEnable[b]) begin
                  r_data[w_tail_m1][8*b +: 8] <= bus.Cpu_WriteData[8*b +: 8];
               end
            end
            r_be[w_tail_m1] <= r_be[w_tail_m1] | bus.Cpu_WriteEnable;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
